// File: rtl/io_cfg_sequencer_if.sv
// rtl/io_cfg_sequencer_if.sv - request, status, readback and pad configuration bundle
interface io_cfg_sequencer_if #(
   parameter int NUM_PADS     = 16,
   parameter int IOCELL_CFG_W = 3,
   parameter int IDX_W        = $clog2(NUM_PADS)
) ();
   logic                             req_valid_in;
   logic                             req_ready_out;
   logic [IDX_W-1:0]                 req_idx_in;
   logic [IOCELL_CFG_W-1:0]          req_cfg_in;
   logic                             done_out;
   logic                             err_out;
   logic                             busy_out;
   logic [IDX_W-1:0]                 rd_idx_in;
   logic [IOCELL_CFG_W-1:0]          rd_cfg_out;
   logic [NUM_PADS*IOCELL_CFG_W-1:0] cfg_out;

   modport slave (
      input  req_valid_in, req_idx_in, req_cfg_in, rd_idx_in,
      output req_ready_out, done_out, err_out, busy_out, rd_cfg_out, cfg_out
   );

   modport master (
      output req_valid_in, req_idx_in, req_cfg_in, rd_idx_in,
      input  req_ready_out, done_out, err_out, busy_out, rd_cfg_out, cfg_out
   );
endinterface

// File: rtl/io_cfg_sequencer.sv
// rtl/io_cfg_sequencer.sv - per-pad IO cell configuration with glitch-safe park-then-switch
module io_cfg_sequencer #(
   parameter int                      NUM_PADS      = 16,
   parameter int                      IOCELL_CFG_W  = 3,
   parameter int                      IDX_W         = $clog2(NUM_PADS),
   parameter logic [IOCELL_CFG_W-1:0] SAFE_CFG      = '0,
   parameter logic [IOCELL_CFG_W-1:0] RESET_CFG     = '0,
   parameter int                      SETTLE_CYCLES = 4
) (
   input  logic             clk_in,
   input  logic             reset_int,
   io_cfg_sequencer_if.slave bus
);
   typedef enum logic {IDLE, HOLD} state_t;

   state_t                           state_q, state_d;
   logic [IOCELL_CFG_W-1:0]          cfg_q [NUM_PADS];
   logic [IDX_W-1:0]                 tgt_idx_q;
   logic [IOCELL_CFG_W-1:0]          pend_cfg_q;
   logic [7:0]                       cnt_q, cnt_d;
   logic                             done_q, done_d, err_q, err_d;
   logic                             wr_en, latch_en, hs, idx_ok;
   logic [IDX_W-1:0]                 wr_idx;
   logic [IOCELL_CFG_W-1:0]          wr_val, cur_cfg, rd_cfg;
   logic [NUM_PADS*IOCELL_CFG_W-1:0] cfg_flat;

   assign hs     = bus.req_valid_in & (state_q == IDLE);
   assign idx_ok = {{(32-IDX_W){1'b0}}, bus.req_idx_in} < NUM_PADS[31:0];

   // Pad muxes decode against real pads only, so out-of-range indices read as 0.
   always_comb begin
      cur_cfg  = '0;
      rd_cfg   = '0;
      cfg_flat = '0;
      for (int i = 0; i < NUM_PADS; i++) begin
         if (bus.req_idx_in == IDX_W'(i)) cur_cfg = cfg_q[i];
         if (bus.rd_idx_in == IDX_W'(i))  rd_cfg  = cfg_q[i];
         cfg_flat[i*IOCELL_CFG_W +: IOCELL_CFG_W] = cfg_q[i];
      end
   end

   always_ff @(posedge clk_in or negedge reset_int) begin
      if (!reset_int) state_q <= IDLE;
      else            state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      done_d   = 1'b0;
      err_d    = 1'b0;
      wr_en    = 1'b0;
      wr_idx   = tgt_idx_q;
      wr_val   = pend_cfg_q;
      latch_en = 1'b0;
      case (state_q)
         IDLE: begin
            if (hs) begin
               if (!idx_ok) begin
                  err_d = 1'b1;
               end else if (bus.req_cfg_in == cur_cfg) begin
                  done_d = 1'b1;
               end else begin
                  wr_en    = 1'b1;
                  wr_idx   = bus.req_idx_in;
                  wr_val   = SAFE_CFG;
                  latch_en = 1'b1;
                  cnt_d    = 8'(SETTLE_CYCLES);
                  state_d  = HOLD;
               end
            end
         end
         HOLD: begin
            cnt_d = cnt_q - 8'd1;
            if (cnt_q == 8'd1) begin
               wr_en   = 1'b1;
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge reset_int) begin
      if (!reset_int) begin
         for (int i = 0; i < NUM_PADS; i++) cfg_q[i] <= RESET_CFG;
         tgt_idx_q  <= '0;
         pend_cfg_q <= '0;
         cnt_q      <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_PADS; i++) begin
            if (wr_en && (wr_idx == IDX_W'(i))) cfg_q[i] <= wr_val;
         end
         if (latch_en) begin
            tgt_idx_q  <= bus.req_idx_in;
            pend_cfg_q <= bus.req_cfg_in;
         end
         cnt_q  <= cnt_d;
         done_q <= done_d;
         err_q  <= err_d;
      end
   end

   assign bus.req_ready_out = (state_q == IDLE);
   assign bus.busy_out      = (state_q == HOLD);
   assign bus.done_out      = done_q;
   assign bus.err_out       = err_q;
   assign bus.rd_cfg_out    = rd_cfg;
   assign bus.cfg_out       = cfg_flat;
endmodule

// File: tb/tb_io_cfg_sequencer.sv
// tb/tb_io_cfg_sequencer.sv - self-checking bench for io_cfg_sequencer
module tb_io_cfg_sequencer;
   localparam int         S    = 4;
   localparam logic [2:0] SAFE = 3'b000;

   logic clk       = 1'b0;
   logic reset_int = 1'b0;
   int   cyc       = 0;
   int   checks    = 0;
   int   errors    = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   io_cfg_sequencer_if #(.NUM_PADS(16), .IOCELL_CFG_W(3), .IDX_W(4)) b16 ();
   io_cfg_sequencer_if #(.NUM_PADS(12), .IOCELL_CFG_W(3), .IDX_W(4)) b12 ();

   io_cfg_sequencer #(.NUM_PADS(16), .IOCELL_CFG_W(3), .IDX_W(4), .SAFE_CFG(3'b000),
                      .RESET_CFG(3'b000), .SETTLE_CYCLES(S))
      dut16 (.clk_in(clk), .reset_int(reset_int), .bus(b16));

   io_cfg_sequencer #(.NUM_PADS(12), .IOCELL_CFG_W(3), .IDX_W(4), .SAFE_CFG(3'b000),
                      .RESET_CFG(3'b000), .SETTLE_CYCLES(S))
      dut12 (.clk_in(clk), .reset_int(reset_int), .bus(b12));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Timeline model: an accepted change at cycle T parks the pad through T+S and lands at T+S+1.
   logic [2:0] m_cfg [16];
   bit         hold_on = 1'b0;
   int         apply_cyc = -1, done_cyc = -1, err_cyc = -1;
   int         tgt = 0;
   logic [2:0] newc = '0;

   always @(negedge clk) begin : compare
      logic [47:0] ef;
      int          ri, qi;
      if (!reset_int) begin
         for (int i = 0; i < 16; i++) m_cfg[i] = 3'b000;
         hold_on  = 1'b0;
         done_cyc = -1;
         err_cyc  = -1;
      end else if (hold_on && cyc == apply_cyc) begin
         m_cfg[tgt] = newc;
         hold_on    = 1'b0;
      end
      for (int i = 0; i < 16; i++) ef[i*3 +: 3] = (hold_on && tgt == i) ? SAFE : m_cfg[i];
      ri = int'(b16.rd_idx_in);
      chk("m_cfg_out", b16.cfg_out, ef);
      chk("m_ready",   b16.req_ready_out, !hold_on);
      chk("m_busy",    b16.busy_out, hold_on);
      chk("m_done",    b16.done_out, cyc == done_cyc);
      chk("m_err",     b16.err_out, cyc == err_cyc);
      chk("m_rd_cfg",  b16.rd_cfg_out, ef[ri*3 +: 3]);
      if (reset_int && b16.req_valid_in && !hold_on) begin
         qi = int'(b16.req_idx_in);
         if (b16.req_cfg_in == ef[qi*3 +: 3]) begin
            done_cyc = cyc + 1;
         end else begin
            hold_on   = 1'b1;
            tgt       = qi;
            newc      = b16.req_cfg_in;
            apply_cyc = cyc + S + 1;
            done_cyc  = cyc + S + 1;
         end
      end
   end

   initial begin : rd_drive
      int n = 0;
      forever begin
         b16.rd_idx_in = 4'((n * 5 + 3) % 16);
         n++;
         @(posedge clk);
         #1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send16(input logic [3:0] idx, input logic [2:0] cfg);
      bit got = 1'b0;
      b16.req_valid_in = 1'b1;
      b16.req_idx_in   = idx;
      b16.req_cfg_in   = cfg;
      for (int k = 0; k < 20 && !got; k++) begin
         @(negedge clk);
         if (b16.req_ready_out) got = 1'b1;
      end
      chk("send_ready", got, 1);
      tick();
      b16.req_valid_in = 1'b0;
   endtask

   task automatic send12(input logic [3:0] idx, input logic [2:0] cfg);
      b12.req_valid_in = 1'b1;
      b12.req_idx_in   = idx;
      b12.req_cfg_in   = cfg;
      @(negedge clk);
      chk("d12_ready", b12.req_ready_out, 1);
      tick();
      b12.req_valid_in = 1'b0;
   endtask

   initial begin : driver
      int  d1, d2;
      bit  seen;
      b16.req_valid_in = 1'b0; b16.req_idx_in = '0; b16.req_cfg_in = '0;
      b12.req_valid_in = 1'b0; b12.req_idx_in = '0; b12.req_cfg_in = '0; b12.rd_idx_in = '0;
      repeat (3) tick();
      chk("rst_cfg", b16.cfg_out, 48'h0);
      chk("rst_ready", b16.req_ready_out, 1);
      reset_int = 1'b1;
      tick();

      // abort pad 3 mid-hold
      send16(4'd3, 3'b111);
      tick();
      chk("abort_busy", b16.busy_out, 1);
      reset_int = 1'b0;
      tick();
      tick();
      chk("abort_cfg", b16.cfg_out, 48'h0);
      chk("abort_ready", b16.req_ready_out, 1);
      reset_int = 1'b1;
      repeat (8) tick();
      chk("abort_f3", b16.cfg_out[11:9], 3'b000);

      // normal change pad 5
      send16(4'd5, 3'b101);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         chk("norm_f5", b16.cfg_out[17:15], (k < 5) ? 3'b000 : 3'b101);
         chk("norm_done", b16.done_out, k == 5);
         chk("norm_busy", b16.busy_out, k < 5);
      end
      tick();

      // fast path
      send16(4'd5, 3'b101);
      @(negedge clk);
      chk("fast_done", b16.done_out, 1);
      chk("fast_ready", b16.req_ready_out, 1);
      chk("fast_f5", b16.cfg_out[17:15], 3'b101);
      tick();

      // back-to-back pad 2 then pad 9
      b16.req_valid_in = 1'b1; b16.req_idx_in = 4'd2; b16.req_cfg_in = 3'b011;
      @(negedge clk);
      chk("b2b_ready0", b16.req_ready_out, 1);
      tick();
      b16.req_idx_in = 4'd9; b16.req_cfg_in = 3'b110;
      seen = 1'b0; d1 = 0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk);
         if (b16.done_out) begin seen = 1'b1; d1 = cyc; end
      end
      chk("b2b_done1_seen", seen, 1);
      chk("b2b_ready_in_done", b16.req_ready_out, 1);
      tick();
      b16.req_valid_in = 1'b0;
      @(negedge clk);
      chk("b2b_busy9", b16.busy_out, 1);
      chk("b2b_f9_safe", b16.cfg_out[29:27], SAFE);
      chk("b2b_f2", b16.cfg_out[8:6], 3'b011);
      seen = 1'b0; d2 = 0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk);
         if (b16.done_out) begin seen = 1'b1; d2 = cyc; end
      end
      chk("b2b_done2_seen", seen, 1);
      chk("b2b_gap", 64'(d2 - d1), 64'd5);
      chk("b2b_f9", b16.cfg_out[29:27], 3'b110);
      tick();

      // request port wiggles during hold are ignored
      send16(4'd7, 3'b010);
      b16.req_valid_in = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         b16.req_idx_in = 4'(k);
         b16.req_cfg_in = 3'b111;
         tick();
      end
      b16.req_valid_in = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("stab_done", b16.done_out, 1);
      chk("stab_f7", b16.cfg_out[23:21], 3'b010);
      chk("stab_f1", b16.cfg_out[5:3], 3'b000);
      chk("stab_f2", b16.cfg_out[8:6], 3'b011);
      tick();

      // 12-pad instance: out-of-range indices
      send12(4'd13, 3'b101);
      @(negedge clk);
      chk("err13_err", b12.err_out, 1);
      chk("err13_done", b12.done_out, 0);
      chk("err13_ready", b12.req_ready_out, 1);
      chk("err13_cfg", b12.cfg_out, 36'h0);
      tick();
      @(negedge clk);
      chk("err13_pulse_end", b12.err_out, 0);
      tick();
      send12(4'd12, 3'b001);
      @(negedge clk);
      chk("err12_err", b12.err_out, 1);
      chk("err12_cfg", b12.cfg_out, 36'h0);
      tick();
      send12(4'd11, 3'b000);
      @(negedge clk);
      chk("fast11_done", b12.done_out, 1);
      chk("fast11_err", b12.err_out, 0);
      tick();
      send12(4'd4, 3'b110);
      repeat (S + 1) tick();
      b12.rd_idx_in = 4'd4;
      @(negedge clk);
      chk("d12_rd4", b12.rd_cfg_out, 3'b110);
      chk("d12_f4", b12.cfg_out[14:12], 3'b110);
      b12.rd_idx_in = 4'd13;
      @(negedge clk);
      chk("d12_rd13", b12.rd_cfg_out, 3'b000);

      repeat (4) tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/io_cfg_sequencer.md
# io_cfg_sequencer

Per-pad configuration controller for the IO ring. It holds the configuration word of every IO cell and drives it onto that cell's configuration input. Configuration changes arrive one at a time over a valid/ready request port from the SoC control register block. Every change is applied glitch-safely: the pad is first parked in a safe configuration for a programmable settle time, and only then switched to its new configuration.

## Interface
- NUM_PADS, 16: number of IO cells controlled (≥2).
- IOCELL_CFG_W, 3: width of one IO cell configuration word.
- IDX_W, $clog2(NUM_PADS): pad index width.
- SAFE_CFG, 3'b000: configuration driven during the settle phase (input/high-Z).
- RESET_CFG, 3'b000: configuration of every pad out of reset.
- SETTLE_CYCLES, 4: cycles the pad is held at SAFE_CFG (1..255).

Ports:
- clk_in  input  1  block clock.
- reset_int  input  1  reset; asynchronous, active-low.
- req_valid_in  input  1  request valid.
- req_ready_out  output  1  request ready; high only in IDLE.
- req_idx_in  input  IDX_W  target pad index.
- req_cfg_in  input  IOCELL_CFG_W  new configuration for the target pad.
- done_out  output  1  one-cycle pulse: request completed.
- err_out  output  1  one-cycle pulse: request rejected (index ≥ NUM_PADS).
- busy_out  output  1  high while in HOLD.
- rd_idx_in  input  IDX_W  readback index.
- rd_cfg_out  output  IOCELL_CFG_W  combinational readback of cfg_out for rd_idx_in; 0 if the index is out of range.
- cfg_out  output  NUM_PADS*IOCELL_CFG_W  flattened per-pad configuration; pad i occupies bits [i*W +: W].

## Operation
- Storage: one IOCELL_CFG_W register per pad (the cfg_out register). Also a target index register, a pending configuration register, and an 8-bit settle counter.
- FSM states: IDLE, HOLD.
- IDLE, on handshake (req_valid_in & req_ready_out):
  - idx ≥ NUM_PADS: err_out pulses next cycle; no register changes; stay IDLE.
  - req_cfg_in equals the pad's current cfg: done_out pulses next cycle; no change; stay IDLE (fast path).
  - Otherwise: pad cfg ← SAFE_CFG; latch idx and cfg; counter ← SETTLE_CYCLES; go to HOLD.
- HOLD:
  - Decrement the counter each cycle.
  - On the cycle where counter == 1: pad cfg ← pending cfg, done_out pulses next cycle, go to IDLE.
  - Inputs on the request port are ignored in HOLD.
- A pending cfg equal to SAFE_CFG still completes the full hold. The result is identical, but timing stays uniform.
- Only the target pad changes; all other pad fields hold their value through every state.
- done_out and err_out are registered and never high together.

## Timing
- Reset (asynchronous assert, synchronous release by the system reset synchroniser):
  - every cfg_out field = RESET_CFG;
  - state IDLE, req_ready_out = 1;
  - done_out = err_out = busy_out = 0;
  - counter = 0.
- Reset asserted during HOLD aborts the request. The target pad goes to RESET_CFG, not to the pending cfg.
- Normal request accepted in cycle T:
  - cfg_out field = SAFE_CFG in cycles T+1 .. T+SETTLE_CYCLES;
  - busy_out = 1 and req_ready_out = 0 in the same cycles;
  - new cfg visible and done_out = 1 in cycle T+SETTLE_CYCLES+1, with req_ready_out = 1 again.
- Back-to-back: a new request can be accepted in the done_out cycle. Its effect (SAFE_CFG on its pad) starts the following cycle.
- Fast-path and error requests: response in T+1. req_ready_out stays high, so a request per cycle is sustainable.
- req_ready_out does not depend combinationally on req_valid_in.
- rd_cfg_out is combinational from the registers, with zero latency. It reflects SAFE_CFG during HOLD.

## Test plan
- Reset: hold reset_int low mid-HOLD on pad 3, then release. Required: all 16 fields = 3'b000, ready = 1, done/err = 0, no completion pulse afterwards.
- Normal change: pad 5 from 000 to 101, request at T, SETTLE_CYCLES = 4. Required:
  - field 5 = 000 for T+1..T+4 and 101 at T+5;
  - done_out pulses only at T+5;
  - busy_out high T+1..T+4;
  - other fields unchanged.
- Fast path: request pad 5 = 101 again. Required: done_out at T+1, ready never drops, cfg unchanged.
- Back-to-back: keep valid high with pad 2 = 011, then pad 9 = 110. Required:
  - pad 9 is accepted in pad 2's done cycle;
  - pad 9 shows SAFE_CFG in the next cycle;
  - two done pulses, 5 cycles apart.
- Error: NUM_PADS = 12, request idx 13. Required: err_out pulse at T+1, no done, all fields unchanged, ready high.
- Request-port stability: change req_idx_in and req_cfg_in during HOLD. Required: the latched pad and cfg are applied; rd_cfg_out tracks rd_idx_in every cycle.
